// File: rtl/output_drain_ctrl.sv
// output_drain_ctrl
// Two loosely coupled halves share this block:
//   - a 4-way round-robin arbiter that lets one processing element per cycle
//     push its result word into an external FIFO;
//   - a drain FSM that copies words from the FIFO head into memory at
//     consecutive word addresses, one Avalon-style write at a time.
// The arbiter runs regardless of whether a drain job is active, so a push and
// a pop may happen in the same cycle.
module output_drain_ctrl #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   clk_en,
  input  logic                   Start,
  input  logic [AddrWidth-1:0]   BaseAddr,
  input  logic [15:0]            WordCount,
  input  logic [3:0]             Req,
  input  logic [4*DataWidth-1:0] ReqData,
  output logic [3:0]             Grant,
  output logic                   Push,
  output logic [DataWidth-1:0]   PushData,
  input  logic                   Full,
  input  logic [15:0]            FifoReady,
  output logic                   Pop2,
  input  logic [DataWidth-1:0]   FifoData,
  output logic [AddrWidth-1:0]   MemAddr,
  output logic [DataWidth-1:0]   MemWriteData,
  output logic                   MemWrite,
  input  logic                   MemWaitReq,
  output logic                   Busy,
  output logic                   Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  prio;
  logic [15:0] remaining;

  logic [1:0]  grant_idx;
  logic [1:0]  scan_idx;
  logic        grant_any;
  logic        fifo_nonempty;

  assign fifo_nonempty = (FifoReady != 16'd0);

  // Round-robin search: first requester at or above the priority pointer,
  // wrapping modulo 4; nothing is granted while the FIFO is full or frozen.
  always_comb begin
    grant_idx = prio;
    scan_idx  = prio;
    grant_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = prio + 2'(k);
      if (!grant_any && Req[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (!clk_en || Full) begin
      grant_any = 1'b0;
    end
  end

  // One-hot grant vector built from the winning index.
  always_comb begin
    Grant = 4'b0000;
    if (grant_any) begin
      Grant[grant_idx] = 1'b1;
    end
  end

  assign Push     = grant_any;
  assign PushData = grant_any ? ReqData[int'(grant_idx)*DataWidth +: DataWidth]
                              : '0;

  // The FIFO head is consumed in the same cycle the FSM latches it.
  assign Pop2 = clk_en && (state == S_WAIT) && fifo_nonempty;

  // Priority pointer moves just past the PE that was served.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      prio <= 2'd0;
    end else if (clk_en && grant_any) begin
      prio <= grant_idx + 2'd1;
    end
  end

  // Drain FSM: latch the job, then alternate WAIT (fetch head word) and
  // WRITE (hold the memory write until the slave stops stalling).
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state        <= S_IDLE;
      MemAddr      <= '0;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
      remaining    <= 16'd0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            MemAddr   <= BaseAddr;
            remaining <= WordCount;
            if (WordCount != 16'd0) begin
              state <= S_WAIT;
              Busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (fifo_nonempty) begin
            MemWriteData <= FifoData;
            MemWrite     <= 1'b1;
            state        <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!MemWaitReq) begin
            MemWrite  <= 1'b0;
            MemAddr   <= MemAddr + AddrWidth'(4);
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= S_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Testbench for output_drain_ctrl: table-driven arbiter vectors, then drain
// jobs checked against a queue of expected memory writes.
module tb_output_drain_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          clk_en = 1'b1;
  logic          Start = 1'b0;
  logic [AW-1:0] BaseAddr = '0;
  logic [15:0]   WordCount = '0;
  logic [3:0]    Req = '0;
  logic [4*DW-1:0] ReqData = '0;
  logic [3:0]    Grant;
  logic          Push;
  logic [DW-1:0] PushData;
  logic          Full = 1'b0;
  logic [15:0]   FifoReady = '0;
  logic          Pop2;
  logic [DW-1:0] FifoData = '0;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWriteData;
  logic          MemWrite;
  logic          MemWaitReq = 1'b0;
  logic          Busy;
  logic          Done;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_wr_t;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic       en;
    logic [3:0] grant;
  } arb_vec_t;

  int            n_tests = 0;
  int            n_fail = 0;
  int            pop_cnt = 0;
  logic          pop_seen = 1'b0;
  logic [DW-1:0] fifo_q[$];
  exp_wr_t       exp_q[$];
  exp_wr_t       mon_w;

  output_drain_ctrl #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk(clk), .aclr(aclr), .clk_en(clk_en),
    .Start(Start), .BaseAddr(BaseAddr), .WordCount(WordCount),
    .Req(Req), .ReqData(ReqData), .Grant(Grant),
    .Push(Push), .PushData(PushData), .Full(Full),
    .FifoReady(FifoReady), .Pop2(Pop2), .FifoData(FifoData),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemWaitReq(MemWaitReq), .Busy(Busy), .Done(Done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pe_word(input int i);
    return DW'(32'h1000_0000 * (i + 1) + 32'h0000_00EE);
  endfunction

  function automatic logic [DW-1:0] onehot_data(input logic [3:0] g);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) d = pe_word(i);
    end
    return d;
  endfunction

  task automatic refresh_fifo();
    if (fifo_q.size() >= 16) FifoReady = 16'hFFFF;
    else FifoReady = 16'((32'd1 << fifo_q.size()) - 32'd1);
    FifoData = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic load_fifo(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    refresh_fifo();
  endtask

  // FIFO model: a Pop2 seen before an edge removes the head just after it.
  always begin
    @(negedge clk);
    pop_seen = Pop2;
    @(posedge clk);
    #1;
    if (pop_seen) begin
      pop_cnt++;
      if (fifo_q.size() > 0) fifo_q.delete(0);
      refresh_fifo();
    end
  end

  // Scoreboard: every accepted memory write must match the oldest expectation.
  always @(negedge clk) begin
    if (!aclr && clk_en && MemWrite && !MemWaitReq) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected none",
                 MemAddr, MemWriteData);
      end else begin
        mon_w = exp_q.pop_front();
        check_output("wr_addr", 64'(MemAddr), 64'(mon_w.addr));
        check_output("wr_data", 64'(MemWriteData), 64'(mon_w.data));
      end
    end
  end

  // Runs one drain job from posedge+1 for a fixed 40-cycle window.
  task automatic apply_stimulus(input logic [AW-1:0] base, input logic [15:0] cnt,
                                input logic [AW-1:0] stall_addr, input logic [DW-1:0] stall_data,
                                input int stall_n, input int freeze_cyc, input int freeze_n,
                                input bit restart,
                                output int done_at, output int done_len, output int hold_len,
                                output int pops, output int bad_frozen, output int busy_mid);
    int      stall_left;
    int      pop_base;
    exp_wr_t e;
    for (int i = 0; i < int'(cnt); i++) begin
      e.addr = base + AW'(4 * i);
      e.data = fifo_q[i];
      exp_q.push_back(e);
    end
    pop_base   = pop_cnt;
    done_at    = -1;
    done_len   = 0;
    hold_len   = 0;
    bad_frozen = 0;
    busy_mid   = 0;
    stall_left = stall_n;
    Start      = 1'b1;
    BaseAddr   = base;
    WordCount  = cnt;
    @(posedge clk);
    #1;
    Start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      clk_en = !(cyc >= freeze_cyc && cyc < freeze_cyc + freeze_n);
      if (MemWrite && MemAddr == stall_addr && stall_left > 0) begin
        MemWaitReq = 1'b1;
        stall_left--;
      end else begin
        MemWaitReq = 1'b0;
      end
      if (restart && (cyc == 2 || cyc == 3)) begin
        Start     = 1'b1;
        BaseAddr  = 32'hDEAD_0000;
        WordCount = 16'd7;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
      if (!clk_en && (Pop2 || Push || Grant != 4'b0000)) bad_frozen++;
      if (MemWrite && MemAddr == stall_addr && MemWriteData == stall_data) hold_len++;
      if (Done) begin
        if (done_at < 0) done_at = cyc;
        done_len++;
      end
      if (cyc == 2) busy_mid = int'(Busy);
      @(posedge clk);
      #1;
    end
    clk_en     = 1'b1;
    MemWaitReq = 1'b0;
    pops       = pop_cnt - pop_base;
  endtask

  // Main sequence: reset, arbiter vectors, drain jobs, abort-on-reset.
  initial begin
    arb_vec_t vecs[$];
    int done_at, done_len, hold_len, pops, bad_frozen, busy_mid;
    int bad_after, aborted, abort_pop_base;

    for (int i = 0; i < 4; i++) ReqData[i*DW +: DW] = pe_word(i);

    for (int i = 0; i < 8; i++) begin
      vecs.push_back('{4'b1111, 1'b0, 1'b1, 4'b0001 << (i % 4)});
    end
    vecs.push_back('{4'b1010, 1'b1, 1'b1, 4'b0000});
    vecs.push_back('{4'b1010, 1'b1, 1'b1, 4'b0000});
    vecs.push_back('{4'b1010, 1'b0, 1'b1, 4'b0010});
    vecs.push_back('{4'b1010, 1'b0, 1'b1, 4'b1000});
    vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b1111, 1'b0, 1'b1, 4'b0001});
    vecs.push_back('{4'b0000, 1'b0, 1'b1, 4'b0000});
    vecs.push_back('{4'b0001, 1'b0, 1'b1, 4'b0001});
    vecs.push_back('{4'b1100, 1'b0, 1'b1, 4'b0100});
    vecs.push_back('{4'b0101, 1'b0, 1'b1, 4'b0001});
    vecs.push_back('{4'b0110, 1'b0, 1'b1, 4'b0010});
    vecs.push_back('{4'b1001, 1'b0, 1'b1, 4'b1000});

    // Reset state, with the arbiter still live under reset.
    #1;
    aclr = 1'b1;
    Req  = 4'b0110;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_grant", 64'(Grant), 64'(4'b0010));
    check_output("rst_push", 64'(Push), 64'd1);
    check_output("rst_pushdata", 64'(PushData), 64'(pe_word(1)));
    check_output("rst_memwrite", 64'(MemWrite), 64'd0);
    check_output("rst_memaddr", 64'(MemAddr), 64'd0);
    check_output("rst_memdata", 64'(MemWriteData), 64'd0);
    check_output("rst_busy", 64'(Busy), 64'd0);
    check_output("rst_done", 64'(Done), 64'd0);
    check_output("rst_pop2", 64'(Pop2), 64'd0);
    Req  = 4'b0000;
    aclr = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < vecs.size(); v++) begin
      Req    = vecs[v].req;
      Full   = vecs[v].full;
      clk_en = vecs[v].en;
      @(negedge clk);
      check_output($sformatf("arb%0d_grant", v), 64'(Grant), 64'(vecs[v].grant));
      check_output($sformatf("arb%0d_push", v), 64'(Push), 64'(vecs[v].grant != 4'b0000));
      check_output($sformatf("arb%0d_data", v), 64'(PushData), 64'(onehot_data(vecs[v].grant)));
      @(posedge clk);
      #1;
    end
    Full   = 1'b0;
    clk_en = 1'b1;
    Req    = 4'b1111;

    // Three words, no stalls: two cycles per word.
    load_fifo(32'hAAAA_0001); load_fifo(32'hBBBB_0002); load_fifo(32'hCCCC_0003);
    apply_stimulus(32'h1000, 16'd3, 32'hFFFF_FFF0, '0, 0, 0, 0, 1'b0,
                   done_at, done_len, hold_len, pops, bad_frozen, busy_mid);
    check_output("j1_done_at", 64'(done_at), 64'd7);
    check_output("j1_done_len", 64'(done_len), 64'd1);
    check_output("j1_pops", 64'(pops), 64'd3);
    check_output("j1_busy_mid", 64'(busy_mid), 64'd1);
    check_output("j1_left", 64'(exp_q.size()), 64'd0);
    check_output("j1_busy_end", 64'(Busy), 64'd0);

    // Word B stalled three cycles by the slave.
    load_fifo(32'hA1A1_0011); load_fifo(32'hB2B2_0022); load_fifo(32'hC3C3_0033);
    apply_stimulus(32'h1000, 16'd3, 32'h1004, 32'hB2B2_0022, 3, 0, 0, 1'b0,
                   done_at, done_len, hold_len, pops, bad_frozen, busy_mid);
    check_output("j2_done_at", 64'(done_at), 64'd10);
    check_output("j2_hold", 64'(hold_len), 64'd4);
    check_output("j2_pops", 64'(pops), 64'd3);
    check_output("j2_left", 64'(exp_q.size()), 64'd0);

    // Zero-length job with a word waiting: no pop, no write.
    load_fifo(32'h5555_0055);
    apply_stimulus(32'h3000, 16'd0, 32'hFFFF_FFF0, '0, 0, 0, 0, 1'b0,
                   done_at, done_len, hold_len, pops, bad_frozen, busy_mid);
    check_output("j3_done_at", 64'(done_at), 64'd1);
    check_output("j3_done_len", 64'(done_len), 64'd1);
    check_output("j3_pops", 64'(pops), 64'd0);
    check_output("j3_busy_mid", 64'(busy_mid), 64'd0);

    // Start pulses while busy must not disturb the running job.
    load_fifo(32'h6666_0066);
    apply_stimulus(32'h3000, 16'd2, 32'hFFFF_FFF0, '0, 0, 0, 0, 1'b1,
                   done_at, done_len, hold_len, pops, bad_frozen, busy_mid);
    check_output("j4_done_at", 64'(done_at), 64'd5);
    check_output("j4_done_len", 64'(done_len), 64'd1);
    check_output("j4_pops", 64'(pops), 64'd2);
    check_output("j4_left", 64'(exp_q.size()), 64'd0);

    // Clock-enable freeze while waiting on a non-empty FIFO.
    load_fifo(32'h7777_0077); load_fifo(32'h8888_0088);
    apply_stimulus(32'h4000, 16'd2, 32'hFFFF_FFF0, '0, 0, 1, 3, 1'b0,
                   done_at, done_len, hold_len, pops, bad_frozen, busy_mid);
    check_output("j5_done_at", 64'(done_at), 64'd8);
    check_output("j5_frozen", 64'(bad_frozen), 64'd0);
    check_output("j5_pops", 64'(pops), 64'd2);

    // Done is held, not re-pulsed, across a freeze.
    apply_stimulus(32'h4000, 16'd0, 32'hFFFF_FFF0, '0, 0, 1, 2, 1'b0,
                   done_at, done_len, hold_len, pops, bad_frozen, busy_mid);
    check_output("j6_done_at", 64'(done_at), 64'd1);
    check_output("j6_done_len", 64'(done_len), 64'd3);

    // Address wraps past the top of the address space.
    load_fifo(32'h9999_0099); load_fifo(32'hABAB_00AB);
    apply_stimulus(32'hFFFF_FFFC, 16'd2, 32'hFFFF_FFF0, '0, 0, 0, 0, 1'b0,
                   done_at, done_len, hold_len, pops, bad_frozen, busy_mid);
    check_output("j7_done_at", 64'(done_at), 64'd5);
    check_output("j7_left", 64'(exp_q.size()), 64'd0);

    // Reset pulse while word 2 of 5 is being written abandons the job.
    for (int i = 0; i < 5; i++) load_fifo(32'hE000_0000 + 32'(i));
    exp_q.push_back('{32'h2000, 32'hE000_0000});
    abort_pop_base = pop_cnt;
    aborted   = 0;
    bad_after = 0;
    Start     = 1'b1;
    BaseAddr  = 32'h2000;
    WordCount = 16'd5;
    @(posedge clk);
    #1;
    Start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      MemWaitReq = 1'b0;
      if (aborted == 0 && MemWrite && MemAddr == 32'h2004) begin
        MemWaitReq = 1'b1;
        #1;
        aclr = 1'b1;
        #1;
        check_output("abort_memwrite", 64'(MemWrite), 64'd0);
        check_output("abort_busy", 64'(Busy), 64'd0);
        aclr    = 1'b0;
        aborted = 1;
      end
      @(negedge clk);
      if (aborted != 0 && (MemWrite || Pop2 || Done || Busy)) bad_after++;
      @(posedge clk);
      #1;
    end
    MemWaitReq = 1'b0;
    check_output("abort_reached", 64'(aborted), 64'd1);
    check_output("abort_quiet", 64'(bad_after), 64'd0);
    check_output("abort_pops", 64'(pop_cnt - abort_pop_base), 64'd2);
    check_output("abort_left", 64'(exp_q.size()), 64'd0);
    fifo_q.delete();
    refresh_fifo();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
